// File: rtl/cnn1d_pkg.sv
// -----------------------------------------------------------------------------
// cnn1d_pkg
// Shared definitions for the 1-D CNN datapath.
//   DATA_WIDTH      sample width used by every stage
//   window_state_t  sliding_window control states (FILL, RUN, DRAIN)
//   pad_width(k)    "same" zero padding on each side of a frame: (k-1)/2
// -----------------------------------------------------------------------------
package cnn1d_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      FILL  = 2'd0,  // fewer than KERNEL_SIZE entries shifted since frame start
      RUN   = 2'd1,  // steady state, windows emitted at STRIDE
      DRAIN = 2'd2   // trailing zero padding injected, input stalled
   } window_state_t;

   function automatic int pad_width(input int k);
      return (k - 1) / 2;
   endfunction

endpackage

// File: rtl/window_shift_reg.sv
// -----------------------------------------------------------------------------
// window_shift_reg
// KERNEL_SIZE-deep shift register. Entries enter at the newest end
// ([KERNEL_SIZE-1]) and age toward [0].
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset (contents zeroed)
//   shift_en   shift one entry in this cycle
//   zero_sel   entry shifted in is zero instead of data_in
//   clear      synchronous clear to all zeros (wins over shift_en)
//   data_in    serial sample
//   read_data  parallel read port: contents with this cycle's entry already
//              shifted in, so a window can be captured on the same edge that
//              accepts its newest sample
// -----------------------------------------------------------------------------
module window_shift_reg
   import cnn1d_pkg::*;
#(
   parameter int KERNEL_SIZE = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  shift_en,
   input  logic                                  zero_sel,
   input  logic                                  clear,
   input  logic [DATA_WIDTH-1:0]                 data_in,
   output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] read_data
);

   logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] taps;

   // NOTE: every variable written in always_comb gets a value on every path
   // (defaults first), otherwise synthesis infers a latch.
   always_comb begin
      read_data = taps;
      for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
         read_data[i] = taps[i+1];
      end
      read_data[KERNEL_SIZE-1] = zero_sel ? '0 : data_in;
   end

   // NOTE: the taps are reset even though they are storage, because zero
   // padding relies on the register holding zeros at frame start.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taps <= '0;
      end else if (clear) begin
         taps <= '0;
      end else if (shift_en) begin
         taps <= read_data;
      end
   end

endmodule

// File: rtl/sliding_window.sv
// -----------------------------------------------------------------------------
// sliding_window
// Serial-to-parallel windowing stage in front of the neuron. Accepts one sample
// per ready/valid transfer and emits KERNEL_SIZE-wide windows every STRIDE
// entries; windows never span a frame of SEQ_LEN samples.
//
// Build option: SLIDING_WINDOW_ZERO_PAD_EN enables "same" zero padding of
// P = (KERNEL_SIZE-1)/2 entries at each end of a frame; trailing padding is
// injected from the DRAIN state. Undefined: no padding, DRAIN unreachable.
//
// Parameters: KERNEL_SIZE (1..SEQ_LEN), STRIDE (>=1), SEQ_LEN.
// Ports:
//   clk               clock
//   rst               asynchronous active-low reset
//   window_ready_in   upstream may transfer a sample
//   window_valid_in   window_data_in is valid
//   window_data_in    serial sample
//   window_ready_out  downstream accepts the window
//   window_valid_out  window_data_out holds a complete window
//   window_data_out   window, [0] oldest .. [KERNEL_SIZE-1] newest
//   window_last_out   final window of the frame
// -----------------------------------------------------------------------------
module sliding_window
   import cnn1d_pkg::*;
#(
   parameter int KERNEL_SIZE = 3,
   parameter int STRIDE      = 1,
   parameter int SEQ_LEN     = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   output logic                                  window_ready_in,
   input  logic                                  window_valid_in,
   input  logic [DATA_WIDTH-1:0]                 window_data_in,
   input  logic                                  window_ready_out,
   output logic                                  window_valid_out,
   output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] window_data_out,
   output logic                                  window_last_out
);

`ifdef SLIDING_WINDOW_ZERO_PAD_EN
   localparam int PAD = pad_width(KERNEL_SIZE);
`else
   localparam int PAD = 0;
`endif

   // Entries per frame including padding, and the pos value of the frame's
   // final window (computed at elaboration, so no divider in hardware).
   localparam int TOTAL    = SEQ_LEN + 2 * PAD;
   localparam int LAST_POS = KERNEL_SIZE + ((TOTAL - KERNEL_SIZE) / STRIDE) * STRIDE;
   localparam int POS_W    = $clog2(TOTAL + 1);
   localparam int CNT_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   typedef logic [POS_W-1:0] pos_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam pos_t POS_START       = pos_t'(PAD);
   localparam pos_t POS_K           = pos_t'(KERNEL_SIZE);
   localparam pos_t POS_SAMPLES_END = pos_t'(SEQ_LEN + PAD);
   localparam pos_t POS_TOTAL       = pos_t'(TOTAL);
   localparam pos_t POS_LAST        = pos_t'(LAST_POS);
   localparam cnt_t CNT_RELOAD      = cnt_t'(STRIDE - 1);

   window_state_t state, state_next;
   pos_t          pos, pos_inc;
   cnt_t          stride_cnt;

   logic out_free;
   logic in_fire;
   logic drain_fire;
   logic shift_en;
   logic window_due;
   logic window_is_last;
   logic sample_end;
   logic drain_end;
   logic enter_drain;
   logic frame_restart;

   logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] shifted;

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         FILL: begin
            if (enter_drain) begin
               state_next = DRAIN;
            end else if (frame_restart) begin
               state_next = FILL;
            end else if (shift_en && (pos_inc == POS_K)) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (enter_drain) begin
               state_next = DRAIN;
            end else if (frame_restart) begin
               state_next = FILL;
            end
         end
         DRAIN: begin
            if (frame_restart) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   // Output register is free when empty or being read this cycle. Input is
   // refused while reset is asserted, while draining padding, or while a
   // window is stalled downstream.
   always_comb begin
      out_free        = !window_valid_out || window_ready_out;
      window_ready_in = rst && (state != DRAIN) && out_free;
      drain_fire      = (state == DRAIN) && out_free;
   end

   // ----------------------------------------------------------- datapath ----
   always_comb begin
      in_fire  = window_valid_in && window_ready_in;
      shift_en = in_fire || drain_fire;
      pos_inc  = pos + 1'b1;

      // First window of a frame is due on reaching KERNEL_SIZE entries; after
      // that, whenever the stride down-counter has run out.
      window_due = 1'b0;
      if (shift_en) begin
         if (pos_inc == POS_K) begin
            window_due = 1'b1;
         end else if ((pos_inc > POS_K) && (stride_cnt == '0)) begin
            window_due = 1'b1;
         end
      end
      window_is_last = (pos_inc == POS_LAST);

      sample_end    = in_fire && (pos_inc == POS_SAMPLES_END);
      drain_end     = drain_fire && (pos_inc == POS_TOTAL);
      enter_drain   = sample_end && (PAD != 0);
      frame_restart = (sample_end && (PAD == 0)) || drain_end;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos        <= POS_START;
         stride_cnt <= CNT_RELOAD;
      end else if (shift_en) begin
         if (frame_restart) begin
            pos        <= POS_START;
            stride_cnt <= CNT_RELOAD;
         end else begin
            pos <= pos_inc;
            if (window_due) begin
               stride_cnt <= CNT_RELOAD;
            end else if (pos_inc > POS_K) begin
               stride_cnt <= stride_cnt - 1'b1;
            end
         end
      end
   end

   // Clearing on frame restart leaves zeros for the leading padding of the
   // next frame; the window captured on that edge comes from 'shifted'.
   window_shift_reg #(
      .KERNEL_SIZE (KERNEL_SIZE)
   ) u_shift_reg (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (shift_en),
      .zero_sel  (drain_fire),
      .clear     (shift_en && frame_restart),
      .data_in   (window_data_in),
      .read_data (shifted)
   );

   // A window only loads when the output register is free, so data and last
   // stay stable for as long as a window is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window_valid_out <= 1'b0;
         window_last_out  <= 1'b0;
         window_data_out  <= '0;
      end else if (window_due) begin
         window_valid_out <= 1'b1;
         window_last_out  <= window_is_last;
         window_data_out  <= shifted;
      end else if (window_ready_out) begin
         window_valid_out <= 1'b0;
      end
   end

endmodule

// File: doc/sliding_window.md
# sliding_window

Serial-to-parallel windowing stage directly upstream of the neuron. It accepts one DATA_WIDTH sample per ready/valid transfer and assembles a KERNEL_SIZE-wide convolution window. Windows are emitted at a configurable STRIDE, so the neuron's NUM_INPUTS port (set equal to KERNEL_SIZE) receives one fully populated window per output transfer. Windows never span a frame of SEQ_LEN samples.

## Interface
- KERNEL_SIZE, 3: window width; must be ≥ 1 and ≤ SEQ_LEN.
- STRIDE, 1: sample advance between consecutive windows; must be ≥ 1.
- SEQ_LEN, 16: samples per frame (one 1-D input sequence).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous assertion, active-low.
- window_ready_in  output  1  upstream may transfer a sample this cycle.
- window_valid_in  input  1  window_data_in is valid.
- window_data_in  input  DATA_WIDTH  serial sample.
- window_ready_out  input  1  downstream (neuron_ready_in) accepts the window.
- window_valid_out  output  1  window_data_out holds a complete window.
- window_data_out  output  DATA_WIDTH × [0:KERNEL_SIZE-1]  window; [0] is the oldest sample, [KERNEL_SIZE-1] the newest.
- window_last_out  output  1  qualifies window_valid_out; high on the final window of a frame.

## Operation
- A transfer in occurs when window_valid_in && window_ready_in. A transfer out occurs when window_valid_out && window_ready_out.
- window_ready_in = (state != DRAIN) && (!window_valid_out || window_ready_out). It is 0 while rst is asserted.
- Each transfer in shifts the sample into a KERNEL_SIZE-deep shift register at the newest end and increments pos, the count of entries shifted since frame start.
- A window is due when pos ≥ KERNEL_SIZE and (pos − KERNEL_SIZE) mod STRIDE == 0. When a window is due, the full shift register is copied into the window_data_out register and window_valid_out is set.
- Stride is tracked with a down-counter reloaded to STRIDE−1 on each emitted window. No divider is used.
- After the SEQ_LEN-th sample of a frame:
  - pos and the stride counter reset to their frame-start values.
  - The shift-register contents are don't-care, because fill restarts.
  - window_last_out is set together with the final window of the frame.
  - Trailing samples that do not complete a stride are consumed and produce no window.
- States: FILL (pos < KERNEL_SIZE), RUN (steady state), DRAIN (padding only; see Configuration).
  - FILL→RUN when pos reaches KERNEL_SIZE.
  - RUN→FILL at end of frame.
  - A new frame's samples are accepted on the cycle immediately after the previous frame's last sample; no bubble.
- Output register behaviour: window_data_out and window_last_out are held stable while window_valid_out && !window_ready_out. window_valid_out clears on a transfer out unless a new window is loaded in the same cycle.
- Reset (asynchronous, mid-operation included):
  - window_valid_out=0, window_last_out=0, window_data_out all zeros.
  - Shift register zeroed, pos=0, stride counter=STRIDE−1, state=FILL.
  - A partially received frame is discarded.

## Timing
- Latency: sample accepted at edge t → its window (if due) is visible with window_valid_out=1 after edge t, i.e. one register stage.
- Throughput: one sample per cycle, and one window per cycle at STRIDE=1.
- Backpressure: window_ready_in falls combinationally from window_valid_out && !window_ready_out. No sample is lost or duplicated.
- Simultaneous transfer out and a new due window in the same cycle: the new window is loaded and window_valid_out stays 1.

## Configuration
- SLIDING_WINDOW_ZERO_PAD_EN defined: "same" zero padding with P = (KERNEL_SIZE−1)/2.
  - At frame start the shift register holds zeros and pos starts at P.
  - After the last sample, state goes to DRAIN. DRAIN injects P zero entries, one per cycle, and only advances when the output register is free. window_ready_in=0 throughout DRAIN.
  - Each injected zero is a shift for the window-due rule. window_last_out marks the final window of the frame, whether it comes from RUN or DRAIN.
  - Windows per frame = (SEQ_LEN + 2P − KERNEL_SIZE)/STRIDE + 1.
- Undefined: no padding and DRAIN is unreachable. Windows per frame = (SEQ_LEN − KERNEL_SIZE)/STRIDE + 1.

## Structure
- cnn1d_pkg gains:
  - typedef window_state_t (FILL, RUN, DRAIN).
  - function pad_width(k) returning (k−1)/2.
  - DATA_WIDTH stays sourced from the package.
- One sub-module, window_shift_reg: a parameterised KERNEL_SIZE-deep shift register with shift enable, zero-inject select and a parallel read port.

## Test plan
- K=3, S=1, L=8, inputs 1..8 streamed every cycle, ready_out=1 → 6 windows (1,2,3)…(6,7,8); last only on (6,7,8); first window valid 1 cycle after sample 3.
- K=3, S=2, L=8 → windows (1,2,3), (3,4,5), (5,6,7) with last on (5,6,7); sample 8 accepted and produces no window.
- Backpressure: K=3, S=1, ready_out held 0 for 3 cycles on window (2,3,4) → data stable and ready_in=0 for those cycles; the full sequence is delivered without loss.
- Back-to-back frames: K=3, L=4, inputs 1..4 then 5..8 → windows (1,2,3), (2,3,4), (5,6,7), (6,7,8); no (3,4,5) or (4,5,6).
- SLIDING_WINDOW_ZERO_PAD_EN, K=3, S=1, L=4, inputs 1..4 → windows (0,1,2), (1,2,3), (2,3,4), (3,4,0) with last on (3,4,0); ready_in=0 during the DRAIN cycle.
- Reset asserted asynchronously after 2 samples of a frame, then released → valid_out=0, outputs zero; the next input is treated as sample 1 of a new frame.
